// File: rtl/cmul_pkg.sv
// Shared types, widths and saturation helper for the complex-multiply sequencer.
package cmul_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 15;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int ACC_W     = PROD_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3,
    OUT
  } cmul_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              clip;
  } sat_t;

  // Takes an already scaled accumulator value and clips it to the DATA_W signed range.
  function automatic sat_t sat_q15(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    sat_t                    r;
    max_v = '0;
    max_v[DATA_W-2:0] = '1;
    min_v = '1;
    min_v[DATA_W-2:0] = '0;
    if (acc > max_v) begin
      r.val  = max_v[DATA_W-1:0];
      r.clip = 1'b1;
    end else if (acc < min_v) begin
      r.val  = min_v[DATA_W-1:0];
      r.clip = 1'b1;
    end else begin
      r.val  = acc[DATA_W-1:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmul_sequencer_mul16s.sv
// Combinational signed DATA_W x DATA_W multiplier shared by all product terms.
module mul16s #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/cmul_sequencer.sv
// Time-multiplexed Q1.15 complex multiplier: one shared multiplier, four cycles per product.
// Build option: define CMUL_ROUND_EN for round-half-up before scaling (default truncates).
module cmul_sequencer
  import cmul_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y_re,
  output logic [DATA_W-1:0] y_im,
  output logic              ovf
);

  localparam int PW = 2 * DATA_W;
  localparam int AW = PW + 1;

  cmul_state_t state, state_nxt;

  logic signed [DATA_W-1:0] ar_q, ai_q, br_q, bi_q;
  logic signed [DATA_W-1:0] mul_a, mul_b;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     prod_x;
  logic signed [AW-1:0]     acc_re, acc_im, acc_im_nxt;
  logic signed [AW-1:0]     re_rnd, im_rnd, re_sh, im_sh;
  sat_t                     sat_re, sat_im;
  logic                     accept;

  mul16s #(
    .DATA_W(DATA_W)
  ) u_mul (
    .a(mul_a),
    .b(mul_b),
    .p(prod)
  );

  assign prod_x    = {prod[PW-1], prod};
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_a     = ar_q;
    mul_b     = br_q;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = M0;
      end
      M0: begin
        mul_a     = ar_q;
        mul_b     = br_q;
        state_nxt = M1;
      end
      M1: begin
        mul_a     = ai_q;
        mul_b     = bi_q;
        state_nxt = M2;
      end
      M2: begin
        mul_a     = ar_q;
        mul_b     = bi_q;
        state_nxt = M3;
      end
      M3: begin
        mul_a     = ai_q;
        mul_b     = br_q;
        state_nxt = OUT;
      end
      OUT: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? M0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  // The imaginary sum is formed combinationally in M3 so the result registers in the same edge.
  always_comb begin
    acc_im_nxt = acc_im + prod_x;
`ifdef CMUL_ROUND_EN
    re_rnd = acc_re + (AW'(1) <<< (FRAC_BITS - 1));
    im_rnd = acc_im_nxt + (AW'(1) <<< (FRAC_BITS - 1));
`else
    re_rnd = acc_re;
    im_rnd = acc_im_nxt;
`endif
    re_sh  = re_rnd >>> FRAC_BITS;
    im_sh  = im_rnd >>> FRAC_BITS;
    sat_re = sat_q15(re_sh);
    sat_im = sat_q15(im_sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ar_q   <= '0;
      ai_q   <= '0;
      br_q   <= '0;
      bi_q   <= '0;
      acc_re <= '0;
      acc_im <= '0;
      y_re   <= '0;
      y_im   <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ar_q   <= a_re;
        ai_q   <= a_im;
        br_q   <= b_re;
        bi_q   <= b_im;
        acc_re <= '0;
        acc_im <= '0;
      end
      case (state)
        M0: acc_re <= prod_x;
        M1: acc_re <= acc_re - prod_x;
        M2: acc_im <= prod_x;
        M3: begin
          acc_im <= acc_im_nxt;
          y_re   <= sat_re.val;
          y_im   <= sat_im.val;
          ovf    <= sat_re.clip | sat_im.clip;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmul_sequencer.sv
// Scoreboard bench for cmul_sequencer: randomized and directed transactions against an arithmetic model.
module tb_cmul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] y_re, y_im;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc_q[$];

  cmul_sequencer #(
    .DATA_W(16),
    .FRAC_BITS(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_re(a_re),
    .a_im(a_im),
    .b_re(b_re),
    .b_im(b_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y_re(y_re),
    .y_im(y_im),
    .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  function automatic void scale(input longint v, output logic [15:0] y, output logic c);
    longint s;
    s = v;
`ifdef CMUL_ROUND_EN
    s = s + 16384;
`endif
    s = s >>> 15;
    if (s > 32767) begin
      y = 16'h7FFF; c = 1'b1;
    end else if (s < -32768) begin
      y = 16'h8000; c = 1'b1;
    end else begin
      y = s[15:0]; c = 1'b0;
    end
  endfunction

  function automatic exp_t model(input logic [15:0] ar, ai, br, bi);
    longint re, im;
    logic   cr, ci;
    exp_t   e;
    re = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ai)) * longint'($signed(bi));
    im = longint'($signed(ar)) * longint'($signed(bi)) + longint'($signed(ai)) * longint'($signed(br));
    scale(re, e.re, cr);
    scale(im, e.im, ci);
    e.ovf = cr | ci;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard: push on accept, compare when a new result is presented.
  logic        prev_valid = 1'b0, prev_taken = 1'b0;
  logic [15:0] held_re, held_im;
  logic        held_ovf;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_taken = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_valid || prev_taken) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out got y=(%h,%h) expected no result", y_re, y_im);
          end else begin
            if ({y_re, y_im, ovf} !== {exp_q[0].re, exp_q[0].im, exp_q[0].ovf}) begin
              errors++;
              $display("FAIL result got (%h,%h,ovf=%b) expected (%h,%h,ovf=%b)",
                       y_re, y_im, ovf, exp_q[0].re, exp_q[0].im, exp_q[0].ovf);
            end
            chk("latency", 32'(cyc - acc_cyc_q[0]), 32'd5);
          end
          held_re  = y_re;
          held_im  = y_im;
          held_ovf = ovf;
        end else begin
          chk("hold_stable", {y_re, y_im}, {held_re, held_im});
          chk("hold_ovf", 32'(ovf), 32'(held_ovf));
        end
        if (!out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(acc_cyc_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a_re, a_im, b_re, b_im));
        acc_cyc_q.push_back(cyc);
      end
      prev_valid = out_valid;
      prev_taken = out_valid && out_ready;
    end
  end

  task automatic send(input logic [15:0] ar, ai, br, bi);
    @(posedge clk);
    #1;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout got in_ready=0 expected 1 within 200 cycles");
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
  endtask

  function automatic logic [15:0] rnd_op();
    logic [15:0] edges [5];
    edges[0] = 16'h8000; edges[1] = 16'h7FFF; edges[2] = 16'h0000;
    edges[3] = 16'h0001; edges[4] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", {y_re, y_im}, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    rdy_mode = 0;
    send(16'h4000, 16'h0000, 16'h4000, 16'h0000);
    idle(6);
    send(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    idle(6);
    send(16'h0001, 16'h0000, 16'h4000, 16'h0000);
    idle(6);

    rdy_mode = 2;
    send(16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF);
    idle(0);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    repeat (6) @(negedge clk);
    rdy_mode = 0;
    drain();

    for (int t = 0; t < 3; t++) send(rnd_op(), rnd_op(), rnd_op(), rnd_op());
    idle(1);
    drain();

    send(16'h1234, 16'hC000, 16'h5A5A, 16'h0F0F);
    idle(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_y", {y_re, y_im}, 32'd0);
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_no_out", 32'(out_valid), 32'd0);
    end
    send(16'h2000, 16'hE000, 16'h6000, 16'h1000);
    idle(1);
    drain();

    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      send(rnd_op(), rnd_op(), rnd_op(), rnd_op());
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    idle(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
